// File: rtl/reflet_int_to_float.sv
// Signed integer to reflet float converter, normalising one bit per clock (optional RNE rounding via REFLET_FLOAT_ROUND_EN).
// Latency: 1 + leading-zero count of |in_int| cycles from accept to out_valid (1 for zero, int_size worst case).
// Backpressure: one operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module reflet_int_to_float #(
    parameter int float_size = 32,
    parameter int int_size   = float_size
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [int_size-1:0]   in_int,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [float_size-1:0] out_float,
    output logic                  out_valid,
    input  logic                  out_ready
);

    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int fs);
        return fs - 1 - exponent_size(fs);
    endfunction

    localparam int E  = exponent_size(float_size);
    localparam int M  = mantissa_size(float_size);
    localparam int F  = int_size - 1;
    localparam int LW = $clog2(int_size) + 1;

    localparam logic [31:0] BIAS    = 32'((1 << (E - 1)) - 1);
    localparam logic [31:0] MAX_EXP = 32'((1 << E) - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic                sign;
    logic [int_size-1:0] mag;
    logic [LW-1:0]       l_cnt;

    logic [31:0]         exp_base;
    logic [31:0]         exp_fin;
    logic [M-1:0]        mant_trunc;
    logic [M-1:0]        mant_fin;
    logic [float_size-1:0] packed_float;

    assign in_ready  = (state == IDLE) && reset;
    assign out_valid = (state == DONE);

    // The magnitude MSB sits at bit F when packing, so the true exponent is F - L.
    assign exp_base   = BIAS + 32'(F) - 32'(l_cnt);
    assign mant_trunc = M'({mag[F-1:0], {M{1'b0}}} >> F);

`ifdef REFLET_FLOAT_ROUND_EN
    localparam int MW = M + 1;
    logic [F+M:0] ext;
    logic         guard;
    logic         sticky;
    logic         round_up;
    logic [M:0]   mant_sum;

    // Extra zero at the bottom keeps the sticky slice legal when int_size is 2.
    assign ext      = {mag[F-1:0], {(M + 1){1'b0}}};
    assign guard    = ext[F];
    assign sticky   = |ext[F-1:0];
    assign round_up = guard && (sticky || mant_trunc[0]);
    assign mant_sum = {1'b0, mant_trunc} + MW'(round_up);
    assign mant_fin = mant_sum[M-1:0];
    assign exp_fin  = exp_base + 32'(mant_sum[M]);
`else
    assign mant_fin = mant_trunc;
    assign exp_fin  = exp_base;
`endif

    always_comb begin
        packed_float = {sign, exp_fin[E-1:0], mant_fin};
        if (exp_fin > MAX_EXP) begin
            packed_float = {sign, {E{1'b1}}, {M{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            l_cnt     <= '0;
            out_float <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign  <= in_int[F];
                        // Unsigned reinterpretation makes the most negative input map to 2^F.
                        mag   <= in_int[F] ? -in_int : in_int;
                        l_cnt <= '0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        out_float <= '0;
                        state     <= DONE;
                    end else if (mag[F]) begin
                        out_float <= packed_float;
                        state     <= DONE;
                    end else begin
                        mag   <= mag << 1;
                        l_cnt <= l_cnt + LW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_int_to_float.sv
// Bench for reflet_int_to_float: 32/32 and 16/16 instances driven through a shared, selectable handshake.
module tb_reflet_int_to_float;

    logic        clk;
    logic        rst_n;
    logic        sel16;
    logic        drv_vld;
    logic        drv_rdy;
    logic [31:0] drv_int;

    logic        r32, v32, r16, v16;
    logic [31:0] f32;
    logic [15:0] f16;

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [31:0] cur_out;

    int checks;
    int errors;

    reflet_int_to_float #(.float_size(32), .int_size(32)) dut32 (
        .clk       (clk),
        .reset     (rst_n),
        .in_int    (drv_int),
        .in_valid  (drv_vld & ~sel16),
        .in_ready  (r32),
        .out_float (f32),
        .out_valid (v32),
        .out_ready (drv_rdy & ~sel16)
    );

    reflet_int_to_float #(.float_size(16), .int_size(16)) dut16 (
        .clk       (clk),
        .reset     (rst_n),
        .in_int    (drv_int[15:0]),
        .in_valid  (drv_vld & sel16),
        .in_ready  (r16),
        .out_float (f16),
        .out_valid (v16),
        .out_ready (drv_rdy & sel16)
    );

    assign cur_in_ready  = sel16 ? r16 : r32;
    assign cur_out_valid = sel16 ? v16 : v32;
    assign cur_out       = sel16 ? {16'h0, f16} : f32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w16;
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model16(input logic [15:0] x, output int lat);
        int   mag, p, frac, sh, mant, e, rem;
        logic s;
        s   = x[15];
        mag = s ? (65536 - int'(x)) : int'(x);
        if (mag == 0) begin
            lat = 1;
            return 16'h0000;
        end
        p = 0;
        for (int i = 0; i < 17; i++) if (mag >= (1 << i)) p = i;
        lat  = 16 - p;
        frac = mag - (1 << p);
        e    = 15 + p;
        if (p >= 10) begin
            sh   = p - 10;
            mant = frac >> sh;
            rem  = frac - (mant << sh);
`ifdef REFLET_FLOAT_ROUND_EN
            if (sh > 0) begin
                if (rem > (1 << (sh - 1)) || (rem == (1 << (sh - 1)) && (mant % 2) == 1)) mant++;
            end
            if (mant == 1024) begin
                mant = 0;
                e++;
            end
`endif
        end else begin
            rem  = 0;
            mant = frac << (10 - p);
        end
        return {s, 5'(e), 10'(mant)};
    endfunction

    task automatic convert(input string name, input logic [31:0] din, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s in_ready", name), 64'(cur_in_ready), 64'd1);
        drv_int = din;
        drv_vld = 1'b1;
        @(negedge clk);
        drv_vld = 1'b0;
        n = 0;
        while (!cur_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s latency", name), 64'(n), 64'(lat));
        chk($sformatf("%s value", name), 64'(cur_out), 64'(exp));
        drv_rdy = 1'b1;
        @(negedge clk);
        drv_rdy = 1'b0;
        chk($sformatf("%s release", name), {62'd0, cur_in_ready, cur_out_valid}, 64'b10);
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] rx;
        logic [15:0] rexp;
        int          rlat;
        int          n;

        checks = 0;
        errors = 0;

        tbl[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 32, "one"};
        tbl[1]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 32, "minus_one"};
        tbl[2]  = '{1'b0, 32'h00000000, 32'h00000000, 1,  "zero"};
        tbl[3]  = '{1'b0, 32'h80000000, 32'hCF000000, 1,  "int_min"};
`ifdef REFLET_FLOAT_ROUND_EN
        tbl[4]  = '{1'b0, 32'h01000003, 32'h4B800002, 8,  "p24_plus3"};
        tbl[8]  = '{1'b0, 32'h7FFFFFFF, 32'h4F000000, 2,  "int_max"};
        tbl[13] = '{1'b1, 32'h00007FFF, 32'h00007800, 2,  "h_int_max"};
`else
        tbl[4]  = '{1'b0, 32'h01000003, 32'h4B800001, 8,  "p24_plus3"};
        tbl[8]  = '{1'b0, 32'h7FFFFFFF, 32'h4EFFFFFF, 2,  "int_max"};
        tbl[13] = '{1'b1, 32'h00007FFF, 32'h000077FF, 2,  "h_int_max"};
`endif
        tbl[5]  = '{1'b0, 32'h01000001, 32'h4B800000, 8,  "p24_plus1"};
        tbl[6]  = '{1'b0, 32'h000003E8, 32'h447A0000, 23, "thousand"};
        tbl[7]  = '{1'b0, 32'hFFFFFFFB, 32'hC0A00000, 30, "minus_five"};
        tbl[9]  = '{1'b0, 32'h00FFFFFF, 32'h4B7FFFFF, 9,  "p24_minus1"};
        tbl[10] = '{1'b1, 32'h000003E8, 32'h000063D0, 7,  "h_thousand"};
        tbl[11] = '{1'b1, 32'h00008000, 32'h0000F800, 1,  "h_int_min"};
        tbl[12] = '{1'b1, 32'h00000001, 32'h00003C00, 16, "h_one"};
        tbl[14] = '{1'b1, 32'h0000FFFF, 32'h0000BC00, 16, "h_minus_one"};

        sel16   = 1'b0;
        drv_vld = 1'b0;
        drv_rdy = 1'b0;
        drv_int = '0;
        rst_n   = 1'b0;
        #1;
        chk("reset state", {30'd0, r32, v32, f32}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", {62'd0, r32, v32}, 64'b10);

        for (int i = 0; i < 15; i++) begin
            sel16 = tbl[i].w16;
            convert(tbl[i].name, tbl[i].din, tbl[i].dout, tbl[i].lat);
        end

        // Backpressure: result held, input ignored while stalled in DONE.
        sel16 = 1'b0;
        @(negedge clk);
        drv_int = 32'd3;
        drv_vld = 1'b1;
        @(negedge clk);
        drv_vld = 1'b0;
        n = 0;
        while (!v32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        held = f32;
        chk("bp value", 64'(held), 64'h40400000);
        for (int i = 0; i < 5; i++) begin
            drv_vld = (i % 2 == 0);
            drv_int = 32'h00000055;
            @(negedge clk);
            chk($sformatf("bp hold %0d", i), {30'd0, v32, r32, f32}, {32'd0, 1'b1, 1'b0, 32'h40400000});
        end
        drv_vld = 1'b0;
        drv_rdy = 1'b1;
        @(negedge clk);
        drv_rdy = 1'b0;
        chk("bp release", {62'd0, r32, v32}, 64'b10);
        repeat (2) @(negedge clk);
        chk("bp no phantom", {62'd0, r32, v32}, 64'b10);

        // Reset in the middle of normalisation.
        @(negedge clk);
        drv_int = 32'd1;
        drv_vld = 1'b1;
        @(negedge clk);
        drv_vld = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset busy", {62'd0, r32, v32}, 64'b00);
        rst_n = 1'b0;
        #1;
        chk("mid reset", {30'd0, r32, v32, f32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset ready", {62'd0, r32, v32}, 64'b10);
        convert("seven", 32'd7, 32'h40E00000, 30);

        sel16 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rx   = 16'($urandom);
            rexp = model16(rx, rlat);
            convert($sformatf("rand16_%0d_%04h", i, rx), {16'h0, rx}, {16'h0, rexp}, rlat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
